// File: rtl/instruction_memory_loader_if.sv
// Download/fetch signal bundle for instruction_memory_loader.
// The loader takes the slave modport and the program source/fetch stage takes the master modport.
interface instruction_memory_loader_if #(
    parameter int NBITS = 32,
    parameter int DEPTH = 64
) ();
    localparam int WCW = $clog2(DEPTH) + 1;

    logic             i_load_start;
    logic             i_byte_valid;
    logic [7:0]       i_byte;
    logic             i_enable;
    logic [NBITS-1:0] i_PC;
    logic [NBITS-1:0] o_Instruction;
    logic             o_halt;
    logic             o_addr_error;
    logic             o_load_done;
    logic [WCW-1:0]   o_word_count;

    modport master (
        output i_load_start, i_byte_valid, i_byte, i_enable, i_PC,
        input  o_Instruction, o_halt, o_addr_error, o_load_done, o_word_count
    );

    modport slave (
        input  i_load_start, i_byte_valid, i_byte, i_enable, i_PC,
        output o_Instruction, o_halt, o_addr_error, o_load_done, o_word_count
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Byte-serial program download into an instruction store, followed by PC-addressed fetch.
// Download order is MSB first; a HALT word or a full store ends the download.
module instruction_memory_loader #(
    parameter int               NBITS     = 32,
    parameter int               DEPTH     = 64,
    parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    instruction_memory_loader_if.slave   bus
);
    localparam int BPW = NBITS / 8;
    localparam int OFS = (BPW > 1) ? $clog2(BPW) : 0;
    localparam int BCW = (OFS > 0) ? OFS : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WCW = $clog2(DEPTH) + 1;
    localparam logic [NBITS-1:0] OFS_MASK = NBITS'(BPW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [NBITS-1:0] asm_q, asm_d;
    logic [WCW-1:0]   word_count_q, word_count_d;
    logic [NBITS-1:0] instr_q, instr_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;

    logic [NBITS-1:0] mem_q [DEPTH];

    logic             word_done_s;
    logic [NBITS-1:0] assembled_s;
    logic             mem_we_s;
    logic [NBITS-1:0] fetch_idx_s;
    logic             misalign_s;
    logic             out_of_range_s;
    logic [NBITS-1:0] rd_word_s;

    assign word_done_s    = (byte_cnt_q == BCW'(BPW - 1));
    assign assembled_s    = (asm_q << 8) | NBITS'(bus.i_byte);
    assign fetch_idx_s    = bus.i_PC >> OFS;
    assign misalign_s     = ((bus.i_PC & OFS_MASK) != {NBITS{1'b0}});
    assign out_of_range_s = (fetch_idx_s >= NBITS'(word_count_q));
    assign rd_word_s      = mem_q[fetch_idx_s[AW-1:0]];

    // Next-state, download datapath and fetch output selection
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        instr_d      = instr_q;
        halt_d       = halt_q;
        err_d        = err_q;
        mem_we_s     = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.i_load_start) begin
                    state_d      = ST_LOAD;
                    byte_cnt_d   = {BCW{1'b0}};
                    asm_d        = {NBITS{1'b0}};
                    word_count_d = {WCW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (bus.i_byte_valid) begin
                    asm_d = assembled_s;
                    if (word_done_s) begin
                        byte_cnt_d   = {BCW{1'b0}};
                        mem_we_s     = 1'b1;
                        word_count_d = word_count_q + WCW'(1);
                        // The HALT word itself is stored before leaving LOAD
                        if ((assembled_s == HALT_WORD) || (word_count_d == WCW'(DEPTH))) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced to NOP whenever the next cycle is not RUN, including a restart from RUN
        if (state_d != ST_RUN) begin
            instr_d = {NBITS{1'b0}};
            halt_d  = 1'b0;
            err_d   = 1'b0;
        end else if ((state_q == ST_RUN) && bus.i_enable) begin
            if (misalign_s || out_of_range_s) begin
                instr_d = {NBITS{1'b0}};
                halt_d  = 1'b0;
                err_d   = 1'b1;
            end else begin
                instr_d = rd_word_s;
                halt_d  = (rd_word_s == HALT_WORD);
                err_d   = 1'b0;
            end
        end else begin
            instr_d = instr_q;
            halt_d  = halt_q;
            err_d   = err_q;
        end
    end

    // Control and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= {BCW{1'b0}};
            asm_q        <= {NBITS{1'b0}};
            word_count_q <= {WCW{1'b0}};
            instr_q      <= {NBITS{1'b0}};
            halt_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
            instr_q      <= instr_d;
            halt_q       <= halt_d;
            err_q        <= err_d;
        end
    end

    // Instruction store; deliberately not reset so contents survive reset and reloads
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            mem_q[word_count_q[AW-1:0]] <= assembled_s;
        end
    end

    assign bus.o_Instruction = instr_q;
    assign bus.o_halt        = halt_q;
    assign bus.o_addr_error  = err_q;
    assign bus.o_load_done   = (state_q == ST_RUN);
    assign bus.o_word_count  = word_count_q;
endmodule

// File: doc/instruction_memory_loader.md
INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, meaning instruction word width (multiple of 8).
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning number of instruction words stored.
REQ-003 The block SHALL have parameter HALT_WORD, default all ones (NBITS bits), meaning the program terminator word.
REQ-004 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-low.
REQ-006 i_load_start  in  1  one-cycle pulse requesting a new program download.
REQ-007 i_byte_valid  in  1  qualifies i_byte for one cycle.
REQ-008 i_byte  in  8  download byte, most-significant byte of each word first.
REQ-009 i_enable  in  1  fetch enable; low = pipeline stall.
REQ-010 i_PC  in  NBITS  byte address of instruction to fetch.
REQ-011 o_Instruction  out  NBITS  registered fetched instruction.
REQ-012 o_halt  out  1  registered; high when o_Instruction equals HALT_WORD.
REQ-013 o_addr_error  out  1  registered; high when last fetch was misaligned or out of range.
REQ-014 o_load_done  out  1  high while in RUN state.
REQ-015 o_word_count  out  clog2(DEPTH)+1  number of words written by last/current download.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN; reset state IDLE.
REQ-017 IDLE -> LOAD on i_load_start; RUN -> LOAD on i_load_start; LOAD ignores i_load_start.
REQ-018 Entering LOAD SHALL clear byte counter, assembly register and o_word_count.
REQ-019 In LOAD each i_byte_valid cycle SHALL shift i_byte into assembly register low end; byte counter increments mod NBITS/8.
REQ-020 On the byte completing a word, the assembled word SHALL be written to memory[o_word_count] and o_word_count incremented in the same cycle.
REQ-021 LOAD -> RUN the cycle after a completed word equals HALT_WORD (the HALT word is stored) or o_word_count reaches DEPTH.
REQ-022 Bytes arriving in IDLE or RUN SHALL be ignored; a partial word pending when i_load_start restarts LOAD is discarded.
REQ-023 Fetch SHALL occur only in RUN with i_enable high: word index = i_PC >> log2(NBITS/8), one-cycle latency to o_Instruction.
REQ-024 Fetch with i_PC low bits nonzero, or index >= o_word_count, SHALL return all zeros (NOP) with o_addr_error high.
REQ-025 Valid fetch SHALL return stored word with o_addr_error low; o_halt SHALL track the returned word.
REQ-026 i_enable low in RUN SHALL hold o_Instruction, o_halt, o_addr_error unchanged.
REQ-027 In IDLE and LOAD, o_Instruction SHALL be zero, o_halt and o_addr_error low, irrespective of i_enable.
REQ-028 Memory contents SHALL persist across LOAD restarts except words overwritten; words at index >= o_word_count are never returned.

Reset
REQ-029 i_reset low SHALL immediately force IDLE, o_Instruction=0, o_halt=0, o_addr_error=0, o_load_done=0, o_word_count=0, byte counter=0.
REQ-030 Reset SHALL NOT clear memory array; reset mid-LOAD abandons the download (o_word_count=0 makes old words unreadable).

Verification
REQ-031 Download bytes 8C 22 00 02, FF FF FF FF -> o_word_count=2, o_load_done high next cycle; i_PC=0 -> o_Instruction=32'h8C220002 one cycle later, o_halt=0; i_PC=4 -> 32'hFFFFFFFF, o_halt=1.
REQ-032 After REQ-031, i_PC=8 -> o_Instruction=0, o_addr_error=1; i_PC=2 -> 0, o_addr_error=1.
REQ-033 Fetch i_PC=0, then i_enable=0 with i_PC=4 for 3 cycles -> o_Instruction holds 32'h8C220002.
REQ-034 Download 64 words without HALT_WORD -> LOAD exits at o_word_count=64; 65th word's bytes ignored; i_PC=252 returns word 63.
REQ-035 Send 6 bytes, assert i_reset low mid-word -> IDLE, all outputs 0; new download of 1 HALT word -> o_word_count=1.
REQ-036 In RUN pulse i_load_start with 2 partial bytes then restart pulse ignored -> bytes continue assembling; i_enable high during LOAD -> o_Instruction stays 0.
